// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, op-field bit positions, named
// operations and the request bundle handed from arbiter to ALU.
package alu_pkg;

   localparam int ALU_W = 16;

   localparam int U   = 4;
   localparam int OP1 = 3;
   localparam int OP0 = 2;
   localparam int ZX  = 1;
   localparam int SW  = 0;

   localparam logic [4:0] OP_ADD = 5'b10000;
   localparam logic [4:0] OP_INC = 5'b10100;
   localparam logic [4:0] OP_SUB = 5'b11000;
   localparam logic [4:0] OP_DEC = 5'b11100;
   localparam logic [4:0] OP_AND = 5'b00000;
   localparam logic [4:0] OP_OR  = 5'b00100;
   localparam logic [4:0] OP_XOR = 5'b01000;
   localparam logic [4:0] OP_NOT = 5'b01100;

   // Function select formed from {u, op1, op0}
   typedef enum logic [2:0] {
      FN_AND = 3'b000,
      FN_OR  = 3'b001,
      FN_XOR = 3'b010,
      FN_NOT = 3'b011,
      FN_ADD = 3'b100,
      FN_INC = 3'b101,
      FN_SUB = 3'b110,
      FN_DEC = 3'b111
   } alu_fn_e;

   typedef struct packed {
      logic [4:0]       op;
      logic [ALU_W-1:0] x;
      logic [ALU_W-1:0] y;
   } alu_req_t;

   // Returns {zero, negative} for a result word
   function automatic logic [1:0] result_flags(input logic [ALU_W-1:0] value);
      return {value == '0, value[ALU_W-1]};
   endfunction

endpackage

// File: rtl/ALU.sv
// 16-bit combinational ALU: optional operand swap, optional zeroing of the
// first operand, then one of eight arithmetic/logic functions.
module ALU
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0] x,
   input  logic [ALU_W-1:0] y,
   input  logic [4:0]       op,
   output logic [ALU_W-1:0] out
);

   localparam logic [ALU_W-1:0] ONE = ALU_W'(1);

   logic [ALU_W-1:0] a;
   logic [ALU_W-1:0] b;
   alu_fn_e          fn;

   assign fn = alu_fn_e'({op[U], op[OP1], op[OP0]});

   // Swap happens before zeroing, so zx always clears whichever operand ends up first
   always_comb begin
      a = op[SW] ? y : x;
      b = op[SW] ? x : y;
      if (op[ZX]) begin
         a = '0;
      end
   end

   always_comb begin
      out = '0;
      case (fn)
         FN_ADD:  out = a + b;
         FN_INC:  out = a + ONE;
         FN_SUB:  out = a - b;
         FN_DEC:  out = a - ONE;
         FN_AND:  out = a & b;
         FN_OR:   out = a | b;
         FN_XOR:  out = a ^ b;
         FN_NOT:  out = ~a;
         default: out = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way arbiter: round-robin or fixed priority, with the last-grant pointer
// advancing only when the granted request is actually accepted.
module rr_arb2 #(
   parameter int RR        = 1,
   parameter int PRIO_INIT = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic valid0,
   input  logic valid1,
   input  logic accept,
   output logic grant,
   output logic grant_valid
);

   localparam logic LAST_INIT = (PRIO_INIT == 0) ? 1'b1 : 1'b0;

   logic last_grant;

   assign grant_valid = valid0 | valid1;

   // Under contention the requester that did not win last time goes next
   always_comb begin
      grant = 1'b0;
      if (valid0 && valid1) begin
         grant = (RR != 0) ? ~last_grant : 1'b0;
      end else if (valid1) begin
         grant = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= LAST_INIT;
      end else if (accept) begin
         last_grant <= grant;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters and returns each result, tagged with
// its requester, through a one-entry valid/ready response buffer.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH     = ALU_W,
   parameter int RR        = 1,
   parameter int PRIO_INIT = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [4:0]       req0_op,
   input  logic [WIDTH-1:0] req0_x,
   input  logic [WIDTH-1:0] req0_y,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [4:0]       req1_op,
   input  logic [WIDTH-1:0] req1_x,
   input  logic [WIDTH-1:0] req1_y,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_zero,
   output logic             rsp_neg
);

   localparam logic ST_EMPTY = 1'b0;
   localparam logic ST_FULL  = 1'b1;

   logic             state;
   logic             can_accept;
   logic             grant;
   logic             grant_valid;
   logic             accept;
   alu_req_t         sel_req;
   logic [WIDTH-1:0] alu_out;

   rr_arb2 #(
      .RR        (RR),
      .PRIO_INIT (PRIO_INIT)
   ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .valid0      (req0_valid),
      .valid1      (req1_valid),
      .accept      (accept),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   // A full buffer can still take a new op when it is being drained this cycle
   assign can_accept = (state == ST_EMPTY) || ((state == ST_FULL) && rsp_ready);

   assign req0_ready = can_accept && grant_valid && !grant && !rst;
   assign req1_ready = can_accept && grant_valid && grant && !rst;
   assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

   always_comb begin
      sel_req = grant ? {req1_op, req1_x, req1_y} : {req0_op, req0_x, req0_y};
   end

   ALU u_alu (
      .x   (sel_req.x),
      .y   (sel_req.y),
      .op  (sel_req.op),
      .out (alu_out)
   );

   // Flags are captured with the same value that lands in rsp_data, so they always describe the held result
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_EMPTY;
         rsp_id   <= 1'b0;
         rsp_data <= '0;
         rsp_zero <= 1'b0;
         rsp_neg  <= 1'b0;
      end else if (accept) begin
         state                <= ST_FULL;
         rsp_id               <= grant;
         rsp_data             <= alu_out;
         {rsp_zero, rsp_neg}  <= result_flags(alu_out);
      end else if ((state == ST_FULL) && rsp_ready) begin
         state <= ST_EMPTY;
      end
   end

   assign rsp_valid = (state == ST_FULL);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_alu_arbiter;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid, rsp_ready;
   logic [4:0]  req0_op, req1_op;
   logic [15:0] req0_x, req0_y, req1_x, req1_y;

   logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero, rsp_neg;
   logic [15:0] rsp_data;
   logic        fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id, fp_rsp_zero, fp_rsp_neg;
   logic [15:0] fp_rsp_data;

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model: buffer contents and whose turn it is under contention
   logic        m_full, m_id, m_last;
   logic [15:0] m_data;
   logic        e_r0, e_r1;

   always #5 clk = ~clk;

   alu_arbiter u_dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_x(req0_x), .req0_y(req0_y),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_x(req1_x), .req1_y(req1_y),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_zero(rsp_zero), .rsp_neg(rsp_neg)
   );

   alu_arbiter #(.RR(0)) u_fp (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_op(req0_op), .req0_x(req0_x), .req0_y(req0_y),
      .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_op(req1_op), .req1_x(req1_x), .req1_y(req1_y),
      .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id), .rsp_data(fp_rsp_data),
      .rsp_zero(fp_rsp_zero), .rsp_neg(fp_rsp_neg)
   );

   function automatic logic [15:0] ref_alu(input logic [4:0] op, input logic [15:0] x, input logic [15:0] y);
      int a, b, r;
      if (op[0]) begin a = y; b = x; end else begin a = x; b = y; end
      if (op[1]) a = 0;
      case (op[4:2])
         3'b100:  r = (a + b) % 65536;
         3'b101:  r = (a + 1) % 65536;
         3'b110:  r = (a - b + 65536) % 65536;
         3'b111:  r = (a + 65535) % 65536;
         3'b000:  r = a & b;
         3'b001:  r = a | b;
         3'b010:  r = a ^ b;
         default: r = 65535 - a;
      endcase
      return 16'(r);
   endfunction

   task automatic predict();
      logic can;
      e_r0 = 1'b0;
      e_r1 = 1'b0;
      can  = !m_full || rsp_ready;
      if (!rst && can) begin
         if (req0_valid && req1_valid) begin
            if (m_last) e_r0 = 1'b1; else e_r1 = 1'b1;
         end else if (req0_valid) e_r0 = 1'b1;
         else if (req1_valid) e_r1 = 1'b1;
      end
   endtask

   task automatic commit();
      if (rst) begin
         m_full = 1'b0; m_id = 1'b0; m_data = 16'h0; m_last = 1'b1;
      end else if (e_r0 || e_r1) begin
         m_full = 1'b1;
         m_id   = e_r1;
         m_last = e_r1;
         m_data = e_r1 ? ref_alu(req1_op, req1_x, req1_y) : ref_alu(req0_op, req0_x, req0_y);
      end else if (m_full && rsp_ready) begin
         m_full = 1'b0;
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_full = 1'b0; m_id = 1'b0; m_data = 16'h0; m_last = 1'b1;
      e_r0 = 1'b0; e_r1 = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_op = OP_ADD; req0_x = 16'd1; req0_y = 16'd2;
      req1_valid = 1'b1; req1_op = OP_ADD; req1_x = 16'd3; req1_y = 16'd4;
      @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++; if (req0_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_ready0 got=%b exp=0", req0_ready); end
      n_checks++; if (req1_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_ready1 got=%b exp=0", req1_ready); end
      @(posedge clk);
      #1;
      n_checks++; if (rsp_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
      n_checks++; if (rsp_id !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_rsp_id got=%b exp=0", rsp_id); end
      n_checks++; if (rsp_data !== 16'h0) begin n_fails++; $display("[TB] FAIL reset_rsp_data got=%h exp=0000", rsp_data); end
      n_checks++; if (rsp_zero !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_rsp_zero got=%b exp=0", rsp_zero); end
      n_checks++; if (rsp_neg !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_rsp_neg got=%b exp=0", rsp_neg); end
   endtask

   typedef struct {
      logic        id;
      logic [4:0]  op;
      logic [15:0] x, y, res;
      logic        z, n;
   } vec_t;

   task automatic test_directed_ops();
      vec_t vecs[7];
      vecs[0] = '{1'b0, OP_ADD,          16'd5,     16'd3,     16'h0008, 1'b0, 1'b0};
      vecs[1] = '{1'b1, OP_SUB | 5'b00001, 16'd5,   16'd3,     16'hFFFE, 1'b0, 1'b1};
      vecs[2] = '{1'b1, OP_SUB | 5'b00010, 16'd7,   16'd7,     16'hFFF9, 1'b0, 1'b1};
      vecs[3] = '{1'b1, OP_XOR,          16'h1234,  16'h1234,  16'h0000, 1'b1, 1'b0};
      vecs[4] = '{1'b0, OP_ADD,          16'hFFFF,  16'h0001,  16'h0000, 1'b1, 1'b0};
      vecs[5] = '{1'b0, OP_DEC,          16'h0000,  16'h5A5A,  16'hFFFF, 1'b0, 1'b1};
      vecs[6] = '{1'b0, OP_NOT,          16'h00FF,  16'h1111,  16'hFF00, 1'b0, 1'b1};
      apply_reset();
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         rsp_ready  = 1'b1;
         req0_valid = !vecs[i].id; req1_valid = vecs[i].id;
         req0_op = vecs[i].op; req0_x = vecs[i].x; req0_y = vecs[i].y;
         req1_op = vecs[i].op; req1_x = vecs[i].x; req1_y = vecs[i].y;
         #1;
         n_checks++; if (req0_ready !== !vecs[i].id) begin n_fails++; $display("[TB] FAIL ops_ready0 vec=%0d got=%b exp=%b", i, req0_ready, !vecs[i].id); end
         n_checks++; if (req1_ready !== vecs[i].id) begin n_fails++; $display("[TB] FAIL ops_ready1 vec=%0d got=%b exp=%b", i, req1_ready, vecs[i].id); end
         @(posedge clk);
         #1;
         n_checks++; if (rsp_valid !== 1'b1) begin n_fails++; $display("[TB] FAIL ops_valid vec=%0d got=%b exp=1", i, rsp_valid); end
         n_checks++; if (rsp_data !== vecs[i].res) begin n_fails++; $display("[TB] FAIL ops_data vec=%0d got=%h exp=%h", i, rsp_data, vecs[i].res); end
         n_checks++; if (rsp_id !== vecs[i].id) begin n_fails++; $display("[TB] FAIL ops_id vec=%0d got=%b exp=%b", i, rsp_id, vecs[i].id); end
         n_checks++; if (rsp_zero !== vecs[i].z) begin n_fails++; $display("[TB] FAIL ops_zero vec=%0d got=%b exp=%b", i, rsp_zero, vecs[i].z); end
         n_checks++; if (rsp_neg !== vecs[i].n) begin n_fails++; $display("[TB] FAIL ops_neg vec=%0d got=%b exp=%b", i, rsp_neg, vecs[i].n); end
      end
   endtask

   task automatic drive_contention();
      req0_valid = 1'b1; req0_op = OP_ADD; req0_x = 16'd1;  req0_y = 16'd1;
      req1_valid = 1'b1; req1_op = OP_ADD; req1_x = 16'd10; req1_y = 16'd10;
   endtask

   task automatic test_round_robin();
      logic exp_id;
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         exp_id = (i % 2 == 1);
         @(negedge clk);
         drive_contention();
         rsp_ready = 1'b1;
         #1;
         n_checks++; if (req0_ready !== !exp_id) begin n_fails++; $display("[TB] FAIL rr_ready0 cyc=%0d got=%b exp=%b", i, req0_ready, !exp_id); end
         n_checks++; if (req1_ready !== exp_id) begin n_fails++; $display("[TB] FAIL rr_ready1 cyc=%0d got=%b exp=%b", i, req1_ready, exp_id); end
         @(posedge clk);
         #1;
         n_checks++; if (rsp_valid !== 1'b1) begin n_fails++; $display("[TB] FAIL rr_valid cyc=%0d got=%b exp=1", i, rsp_valid); end
         n_checks++; if (rsp_id !== exp_id) begin n_fails++; $display("[TB] FAIL rr_id cyc=%0d got=%b exp=%b", i, rsp_id, exp_id); end
         n_checks++; if (rsp_data !== (exp_id ? 16'd20 : 16'd2)) begin n_fails++; $display("[TB] FAIL rr_data cyc=%0d got=%h exp=%h", i, rsp_data, exp_id ? 16'd20 : 16'd2); end
      end
   endtask

   task automatic test_fixed_priority();
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drive_contention();
         rsp_ready = 1'b1;
         #1;
         n_checks++; if (fp_req0_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL fp_ready0 cyc=%0d got=%b exp=1", i, fp_req0_ready); end
         n_checks++; if (fp_req1_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL fp_ready1 cyc=%0d got=%b exp=0", i, fp_req1_ready); end
         @(posedge clk);
         #1;
         n_checks++; if (fp_rsp_id !== 1'b0) begin n_fails++; $display("[TB] FAIL fp_id cyc=%0d got=%b exp=0", i, fp_rsp_id); end
         n_checks++; if (fp_rsp_data !== 16'd2) begin n_fails++; $display("[TB] FAIL fp_data cyc=%0d got=%h exp=0002", i, fp_rsp_data); end
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      @(negedge clk);
      req0_valid = 1'b1; req0_op = OP_ADD; req0_x = 16'd5; req0_y = 16'd3; rsp_ready = 1'b1;
      #1;
      n_checks++; if (req0_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL bp_first_ready got=%b exp=1", req0_ready); end
      @(posedge clk);
      @(negedge clk);
      req0_op = OP_SUB; req0_x = 16'd9; req0_y = 16'd4;
      req1_valid = 1'b1; req1_op = OP_OR; req1_x = 16'h00F0; req1_y = 16'h000F;
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL bp_readys cyc=%0d got=%b%b exp=00", i, req0_ready, req1_ready); end
         @(posedge clk);
         #1;
         n_checks++; if (rsp_valid !== 1'b1) begin n_fails++; $display("[TB] FAIL bp_valid cyc=%0d got=%b exp=1", i, rsp_valid); end
         n_checks++; if (rsp_data !== 16'h0008 || rsp_id !== 1'b0) begin n_fails++; $display("[TB] FAIL bp_hold cyc=%0d got=%h/%b exp=0008/0", i, rsp_data, rsp_id); end
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      #1;
      n_checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL bp_release_readys got=%b%b exp=01", req0_ready, req1_ready); end
      @(posedge clk);
      #1;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 16'h00FF) begin n_fails++; $display("[TB] FAIL bp_release_rsp got=%b/%b/%h exp=1/1/00ff", rsp_valid, rsp_id, rsp_data); end
      @(negedge clk);
      req1_valid = 1'b0;
      #1;
      n_checks++; if (req0_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL bp_next_ready0 got=%b exp=1", req0_ready); end
      @(posedge clk);
      #1;
      n_checks++; if (rsp_id !== 1'b0 || rsp_data !== 16'h0005) begin n_fails++; $display("[TB] FAIL bp_next_rsp got=%b/%h exp=0/0005", rsp_id, rsp_data); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      @(negedge clk);
      req0_valid = 1'b1; req0_op = OP_ADD; req0_x = 16'd5; req0_y = 16'd3; rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      n_checks++; if (rsp_valid !== 1'b1) begin n_fails++; $display("[TB] FAIL mid_setup_valid got=%b exp=1", rsp_valid); end
      @(negedge clk);
      rst = 1'b1; rsp_ready = 1'b0;
      drive_contention();
      #1;
      n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_readys got=%b%b exp=00", req0_ready, req1_ready); end
      @(posedge clk);
      #1;
      n_checks++; if (rsp_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_valid got=%b exp=0", rsp_valid); end
      @(negedge clk);
      rst = 1'b0; rsp_ready = 1'b1;
      #1;
      n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_first_grant got=%b%b exp=10", req0_ready, req1_ready); end
      @(posedge clk);
      #1;
      n_checks++; if (rsp_id !== 1'b0 || rsp_data !== 16'd2) begin n_fails++; $display("[TB] FAIL mid_rsp got=%b/%h exp=0/0002", rsp_id, rsp_data); end
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!(req0_valid && !e_r0)) begin
            req0_valid = 1'($urandom_range(0, 1));
            req0_op = 5'($urandom_range(0, 31)); req0_x = 16'($urandom); req0_y = 16'($urandom);
            if ($urandom_range(0, 7) == 0) req0_y = req0_x;
         end
         if (!(req1_valid && !e_r1)) begin
            req1_valid = 1'($urandom_range(0, 1));
            req1_op = 5'($urandom_range(0, 31)); req1_x = 16'($urandom); req1_y = 16'($urandom);
            if ($urandom_range(0, 7) == 0) req1_y = req1_x;
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         predict();
         n_checks++; if (req0_ready !== e_r0) begin n_fails++; $display("[TB] FAIL rand_ready0 cyc=%0d got=%b exp=%b", i, req0_ready, e_r0); end
         n_checks++; if (req1_ready !== e_r1) begin n_fails++; $display("[TB] FAIL rand_ready1 cyc=%0d got=%b exp=%b", i, req1_ready, e_r1); end
         @(posedge clk);
         commit();
         #1;
         n_checks++; if (rsp_valid !== m_full) begin n_fails++; $display("[TB] FAIL rand_valid cyc=%0d got=%b exp=%b", i, rsp_valid, m_full); end
         if (m_full) begin
            n_checks++; if (rsp_data !== m_data) begin n_fails++; $display("[TB] FAIL rand_data cyc=%0d got=%h exp=%h", i, rsp_data, m_data); end
            n_checks++; if (rsp_id !== m_id) begin n_fails++; $display("[TB] FAIL rand_id cyc=%0d got=%b exp=%b", i, rsp_id, m_id); end
            n_checks++; if (rsp_zero !== (m_data == 16'h0)) begin n_fails++; $display("[TB] FAIL rand_zero cyc=%0d got=%b exp=%b", i, rsp_zero, m_data == 16'h0); end
            n_checks++; if (rsp_neg !== m_data[15]) begin n_fails++; $display("[TB] FAIL rand_neg cyc=%0d got=%b exp=%b", i, rsp_neg, m_data[15]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed_ops();
      test_round_robin();
      test_fixed_priority();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
